// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store/push/pop sequencer in front of the 8-bit data
// memory. Each accepted request takes one ACCESS cycle (memory pins driven)
// followed by one RESP cycle (rsp_valid pulse). Stack errors skip ACCESS and
// go straight to RESP with rsp_err set. Owns the hardware stack pointer.
module mem_access_unit #(
  parameter int unsigned   AW       = 8,
  parameter int unsigned   DW       = 8,
  parameter logic [AW-1:0] SP_INIT  = 8'hFF,
  parameter logic [AW-1:0] SP_LIMIT = 8'hC0
) (
  input  logic          clk,
  input  logic          rst,
  // request channel from execute
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [1:0]    req_op,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  // response channel
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_err,
  // status
  output logic [AW-1:0] sp,
  output logic          busy,
  // data memory pins
  output logic [AW-1:0] mem_address,
  output logic [DW-1:0] mem_in_data,
  input  logic [DW-1:0] mem_out_data,
  output logic          mem_w_en,
  output logic          mem_en
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'b00,
    OP_STORE = 2'b01,
    OP_PUSH  = 2'b10,
    OP_POP   = 2'b11
  } op_e;

  // Stack is full once sp has moved one below the lowest pushable address.
  localparam logic [AW-1:0] SP_FULL = SP_LIMIT - AW'(1);

  state_e        state_q, state_d;
  op_e           op_q, op_d;
  logic [AW-1:0] eff_q, eff_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [AW-1:0] sp_q, sp_d;
  logic [DW-1:0] rsp_data_q, rsp_data_d;
  logic          rsp_err_q, rsp_err_d;

  logic          ready_raw;
  logic          accept;
  logic          is_write_q;
  op_e           req_op_e;

  assign req_op_e   = op_e'(req_op);
  assign is_write_q = (op_q == OP_STORE) || (op_q == OP_PUSH);

  // req_ready is masked by rst directly so it stays low for the whole reset
  // pulse and rises in the first cycle after release.
  assign req_ready = ready_raw & ~rst;
  assign accept    = req_valid & req_ready;

  // State register and datapath registers.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the values computed in the previous combinational pass.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_LOAD;
      eff_q      <= '0;
      wdata_q    <= '0;
      sp_q       <= SP_INIT;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      eff_q      <= eff_d;
      wdata_q    <= wdata_d;
      sp_q       <= sp_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  // Next-state logic and memory/handshake outputs.
  always_comb begin
    // NOTE: every variable written here gets a default first; a missing
    // default on any path would infer a latch.
    state_d     = state_q;
    op_d        = op_q;
    eff_d       = eff_q;
    wdata_d     = wdata_q;
    sp_d        = sp_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    ready_raw   = 1'b0;
    rsp_valid   = 1'b0;
    mem_en      = 1'b0;
    mem_w_en    = 1'b0;
    mem_address = '0;
    mem_in_data = '0;

    unique case (state_q)
      ST_IDLE: begin
        ready_raw = 1'b1;
        if (accept) begin
          op_d    = req_op_e;
          wdata_d = req_wdata;
          state_d = ST_ACCESS;
          unique case (req_op_e)
            OP_LOAD, OP_STORE: eff_d = req_addr;
            OP_PUSH: begin
              eff_d = sp_q;
              if (sp_q == SP_FULL) begin
                state_d    = ST_RESP;
                rsp_err_d  = 1'b1;
                rsp_data_d = '0;
              end
            end
            OP_POP: begin
              eff_d = sp_q + AW'(1);
              if (sp_q == SP_INIT) begin
                state_d    = ST_RESP;
                rsp_err_d  = 1'b1;
                rsp_data_d = '0;
              end
            end
            default: eff_d = req_addr;
          endcase
        end
      end

      ST_ACCESS: begin
        mem_en      = 1'b1;
        mem_address = eff_q;
        mem_w_en    = is_write_q;
        mem_in_data = is_write_q ? wdata_q : '0;
        rsp_err_d   = 1'b0;
        rsp_data_d  = is_write_q ? '0 : mem_out_data;
        if (op_q == OP_PUSH) sp_d = sp_q - AW'(1);
        if (op_q == OP_POP)  sp_d = sp_q + AW'(1);
        state_d = ST_RESP;
      end

      ST_RESP: begin
        rsp_valid = 1'b1;
        state_d   = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign rsp_data = rsp_data_q;
  assign rsp_err  = rsp_err_q;
  assign sp       = sp_q;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural 256x8 data memory.
module tb_mem_access_unit;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_STORE = 2'b01;
  localparam logic [1:0] OP_PUSH  = 2'b10;
  localparam logic [1:0] OP_POP   = 2'b11;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_op;
  logic [7:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic [7:0] sp;
  logic       busy;
  logic [7:0] mem_address;
  logic [7:0] mem_in_data;
  logic [7:0] mem_out_data;
  logic       mem_w_en;
  logic       mem_en;

  int errors = 0;
  int checks = 0;

  logic [7:0] mem [256];
  bit         mem_loaded = 1'b0;
  int         write_cnt = 0;
  int         en_cnt = 0;
  int         rsp_cnt = 0;
  int         accept_cnt = 0;
  logic [7:0] exp_sp;

  mem_access_unit dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .rsp_err      (rsp_err),
    .sp           (sp),
    .busy         (busy),
    .mem_address  (mem_address),
    .mem_in_data  (mem_in_data),
    .mem_out_data (mem_out_data),
    .mem_w_en     (mem_w_en),
    .mem_en       (mem_en)
  );

  always #5 clk = ~clk;

  // Combinational-read memory with a known background pattern.
  assign mem_out_data = mem[mem_address];

  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'hA5;
      mem_loaded <= 1'b1;
    end else if (mem_en && mem_w_en) begin
      mem[mem_address] <= mem_in_data;
    end
    if (mem_en && mem_w_en) write_cnt <= write_cnt + 1;
    if (mem_en) en_cnt <= en_cnt + 1;
    if (rsp_valid) rsp_cnt <= rsp_cnt + 1;
    if (req_valid && req_ready) accept_cnt <= accept_cnt + 1;
  end

  // One full request: accept, ACCESS (unless error), RESP, back to IDLE.
  // Starts in IDLE low phase and returns at a falling edge in IDLE.
  task automatic run_req(input logic [1:0] op, input logic [7:0] addr,
                         input logic [7:0] wdata, input bit exp_err,
                         input logic [7:0] exp_rdata, input string name);
    logic [7:0]  exp_addr;
    bit          wr;
    bit          got_ready;
    logic [19:0] acc_act, acc_exp;
    logic [11:0] rsp_act, rsp_exp;
    logic [18:0] idl_act, idl_exp;
    wr = (op == OP_STORE) || (op == OP_PUSH);
    exp_addr = (op == OP_PUSH) ? exp_sp : (op == OP_POP) ? exp_sp + 8'd1 : addr;
    req_op = op; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    got_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (req_ready) begin got_ready = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (!got_ready) begin
      errors++;
      $display("FAIL %s ready_timeout: req_ready=%b required 1", name, req_ready);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_op = 2'b01; req_addr = 8'hEE; req_wdata = 8'hEE;
    @(negedge clk);
    if (!exp_err) begin
      acc_act = {rsp_valid, req_ready, mem_en, mem_w_en, mem_address, mem_in_data};
      acc_exp = {1'b0, 1'b0, 1'b1, wr, exp_addr, (wr ? wdata : 8'h00)};
      checks++;
      if (acc_act !== acc_exp) begin
        errors++;
        $display("FAIL %s access {vld,rdy,en,wen,addr,din}: got %h required %h",
                 name, acc_act, acc_exp);
      end
      @(negedge clk);
      if (op == OP_PUSH) exp_sp = exp_sp - 8'd1;
      if (op == OP_POP)  exp_sp = exp_sp + 8'd1;
    end
    rsp_act = {rsp_valid, rsp_err, rsp_data, req_ready, mem_en};
    rsp_exp = {1'b1, exp_err, exp_rdata, 1'b0, 1'b0};
    checks++;
    if (rsp_act !== rsp_exp) begin
      errors++;
      $display("FAIL %s resp {vld,err,data,rdy,en}: got %h required %h",
               name, rsp_act, rsp_exp);
    end
    @(negedge clk);
    idl_act = {req_ready, rsp_valid, rsp_err, rsp_data, sp};
    idl_exp = {1'b1, 1'b0, exp_err, exp_rdata, exp_sp};
    checks++;
    if (idl_act !== idl_exp) begin
      errors++;
      $display("FAIL %s idle {rdy,vld,err,data,sp}: got %h required %h",
               name, idl_act, idl_exp);
    end
  endtask

  task automatic test_reset();
    logic [20:0] act;
    @(negedge clk);
    act = {req_ready, rsp_valid, rsp_err, mem_en, mem_w_en, mem_address, mem_in_data};
    checks++;
    if (act !== 21'h0) begin
      errors++;
      $display("FAIL reset_held: got %h required %h", act, 21'h0);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({req_ready, sp, mem_en, rsp_valid, rsp_data, busy} !== {1'b1, 8'hFF, 1'b0, 1'b0, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL reset_release {rdy,sp,en,vld,data,busy}: got %h required %h",
               {req_ready, sp, mem_en, rsp_valid, rsp_data, busy},
               {1'b1, 8'hFF, 1'b0, 1'b0, 8'h00, 1'b0});
    end
    exp_sp = 8'hFF;
  endtask

  task automatic test_store_load();
    run_req(OP_STORE, 8'h09, 8'h45, 1'b0, 8'h00, "store_09");
    checks++;
    if (mem[8'h09] !== 8'h45) begin
      errors++;
      $display("FAIL store_09_mem: got %h required %h", mem[8'h09], 8'h45);
    end
    run_req(OP_LOAD, 8'h09, 8'h00, 1'b0, 8'h45, "load_09");
    run_req(OP_LOAD, 8'h30, 8'h00, 1'b0, 8'h95, "load_30_background");
  endtask

  task automatic test_push_pop();
    run_req(OP_PUSH, 8'h00, 8'h54, 1'b0, 8'h00, "push_54");
    run_req(OP_PUSH, 8'h00, 8'h04, 1'b0, 8'h00, "push_04");
    checks++;
    if ({mem[8'hFF], mem[8'hFE], sp} !== {8'h54, 8'h04, 8'hFD}) begin
      errors++;
      $display("FAIL push_mem {mFF,mFE,sp}: got %h required %h",
               {mem[8'hFF], mem[8'hFE], sp}, {8'h54, 8'h04, 8'hFD});
    end
    run_req(OP_POP, 8'h00, 8'h00, 1'b0, 8'h04, "pop_04");
    run_req(OP_POP, 8'h00, 8'h00, 1'b0, 8'h54, "pop_54");
  endtask

  task automatic test_underflow();
    int en_before;
    en_before = en_cnt;
    run_req(OP_POP, 8'h00, 8'h00, 1'b1, 8'h00, "pop_empty");
    checks++;
    if (en_cnt !== en_before) begin
      errors++;
      $display("FAIL pop_empty_no_access: got %0d enables required %0d", en_cnt, en_before);
    end
  endtask

  task automatic test_overflow();
    int wr_before;
    for (int i = 0; i < 64; i++)
      run_req(OP_PUSH, 8'h00, 8'(i), 1'b0, 8'h00, "fill_push");
    wr_before = write_cnt;
    run_req(OP_PUSH, 8'h00, 8'hAA, 1'b1, 8'h00, "push_full");
    checks++;
    if ({write_cnt, sp, mem[8'hC0], mem[8'hBF]} !== {wr_before, 8'hBF, 8'h3F, 8'h1A}) begin
      errors++;
      $display("FAIL push_full_state {writes,sp,mC0,mBF}: got %h required %h",
               {write_cnt, sp, mem[8'hC0], mem[8'hBF]}, {wr_before, 8'hBF, 8'h3F, 8'h1A});
    end
  endtask

  task automatic test_back_to_back();
    int wr_before, acc_before, waits;
    wr_before = write_cnt;
    acc_before = accept_cnt;
    req_op = OP_STORE; req_addr = 8'h00; req_wdata = 8'h33; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_addr = 8'h01; req_wdata = 8'h40;
    waits = 0;
    @(negedge clk);
    while (!req_ready && waits < 8) begin
      waits++;
      @(negedge clk);
    end
    checks++;
    if (waits !== 2) begin
      errors++;
      $display("FAIL b2b_ready_gap: got %0d low cycles required 2", waits);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({write_cnt - wr_before, accept_cnt - acc_before} !== {32'd2, 32'd2}) begin
      errors++;
      $display("FAIL b2b_counts {writes,accepts}: got %0d,%0d required 2,2",
               write_cnt - wr_before, accept_cnt - acc_before);
    end
    checks++;
    if ({mem[8'h00], mem[8'h01], req_ready} !== {8'h33, 8'h40, 1'b1}) begin
      errors++;
      $display("FAIL b2b_mem {m00,m01,rdy}: got %h required %h",
               {mem[8'h00], mem[8'h01], req_ready}, {8'h33, 8'h40, 1'b1});
    end
  endtask

  task automatic test_reset_abort();
    int wr_before, rsp_before;
    wr_before = write_cnt;
    req_op = OP_STORE; req_addr = 8'h0D; req_wdata = 8'h14; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    #1;
    rsp_before = rsp_cnt;
    checks++;
    if ({mem_en, mem_w_en, mem_address} !== {1'b1, 1'b1, 8'h0D}) begin
      errors++;
      $display("FAIL abort_pre {en,wen,addr}: got %h required %h",
               {mem_en, mem_w_en, mem_address}, {1'b1, 1'b1, 8'h0D});
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({mem_en, mem_w_en, mem_address, rsp_valid, req_ready, sp} !== {4'b0000, 8'h00, 8'hFF}) begin
      errors++;
      $display("FAIL abort_async {en,wen,addr,vld,rdy,sp}: got %h required %h",
               {mem_en, mem_w_en, mem_address, rsp_valid, req_ready, sp},
               {4'b0000, 8'h00, 8'hFF});
    end
    @(negedge clk);
    rst = 1'b0;
    exp_sp = 8'hFF;
    repeat (2) @(negedge clk);
    checks++;
    if ({rsp_cnt - rsp_before, write_cnt - wr_before} !== {32'd0, 32'd0}) begin
      errors++;
      $display("FAIL abort_no_effect {rsps,writes}: got %0d,%0d required 0,0",
               rsp_cnt - rsp_before, write_cnt - wr_before);
    end
    run_req(OP_LOAD, 8'h0D, 8'h00, 1'b0, 8'hA8, "load_after_abort");
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0;
    req_op = 2'b00;
    req_addr = 8'h00;
    req_wdata = 8'h00;
    exp_sp = 8'hFF;
    repeat (2) @(posedge clk);
    test_reset();
    test_store_load();
    test_push_pop();
    test_underflow();
    test_back_to_back();
    test_overflow();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store sequencer that sits directly upstream of the 8-bit data memory (mem8) in the Harvard datapath.
- Accepts LOAD/STORE/PUSH/POP requests from the execute stage over a valid/ready handshake.
- Drives the memory's address, in_data, w_en and en pins for exactly one cycle per access, then returns the loaded byte or completion status.
- Owns the hardware stack pointer used by PUSH/POP.

Parameters:
- AW, 8, memory address width.
- DW, 8, data width.
- SP_INIT, 8'hFF, stack pointer value after reset; the stack is empty at this value.
- SP_LIMIT, 8'hC0, lowest address a PUSH may write; the stack is full when sp == SP_LIMIT-1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_op  in  2  operation: 00 LOAD, 01 STORE, 10 PUSH, 11 POP.
- req_addr  in  AW  address for LOAD/STORE; ignored for PUSH/POP.
- req_wdata  in  DW  write data for STORE/PUSH.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_data  out  DW  loaded byte (LOAD/POP); 0 otherwise.
- rsp_err  out  1  qualifies rsp_valid; stack overflow or underflow.
- sp  out  AW  current stack pointer.
- busy  out  1  high in any state other than IDLE.
- mem_address  out  AW  to data memory address.
- mem_in_data  out  DW  to data memory in_data.
- mem_out_data  in  DW  from data memory out_data; combinational read.
- mem_w_en  out  1  to data memory w_en.
- mem_en  out  1  to data memory en.

Behaviour:
- Reset (async, while rst=1):
  - state=IDLE, sp=SP_INIT.
  - rsp_valid=0, rsp_err=0, rsp_data=0.
  - mem_en=0, mem_w_en=0, mem_address=0, mem_in_data=0.
  - req_ready=0 while rst is high; it goes high in the first cycle after rst deasserts.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - req_ready=1.
  - Accept on req_valid&req_ready at a rising edge; latch op, addr, wdata.
  - Compute the effective address and error:
    - LOAD/STORE: eff = req_addr.
    - PUSH: eff = sp. Error if sp == SP_LIMIT-1 (full).
    - POP: eff = sp+1 (mod 256). Error if sp == SP_INIT (empty).
  - Next state is ACCESS, or RESP directly if error.
- ACCESS (exactly 1 cycle):
  - mem_en=1, mem_address=eff.
  - mem_w_en=1 for STORE/PUSH, else 0.
  - mem_in_data=latched wdata for writes, 0 for reads.
  - For LOAD/POP, sample mem_out_data into rsp_data at the closing edge.
  - At the same edge: PUSH sets sp<=sp-1; POP sets sp<=sp+1.
  - Next state is RESP.
- RESP (exactly 1 cycle):
  - rsp_valid=1.
  - rsp_err=1 only for the error path.
  - rsp_data holds the read byte for LOAD/POP; 0 for STORE/PUSH/error.
  - Next state is IDLE.
- Outside ACCESS, mem_en=0 and mem_w_en=0. The memory is never written except in ACCESS.
- Latency: a request accepted at edge N gives ACCESS during cycle N+1 and rsp_valid during cycle N+2. An error request gives rsp_valid during cycle N+1.
- Throughput: one request per 3 cycles (2 cycles on error). req_ready=0 in ACCESS and RESP; req_valid held then is not accepted until IDLE.
- rsp_data and rsp_err hold their value after RESP until the next RESP; rsp_valid is the only qualifier.
- An error leaves sp unchanged and issues no memory access.
- sp arithmetic is unsigned AW-bit modulo, but the limits above prevent wrap in legal use.
- Reset mid-ACCESS aborts immediately:
  - mem_en drops asynchronously.
  - No rsp_valid is issued.
  - sp returns to SP_INIT.
- req_op, req_addr and req_wdata are ignored when not accepted.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, release -> req_ready=1, sp=8'hFF, mem_en=0, rsp_valid=0.
- STORE 45 @0x09, then LOAD @0x09 -> during ACCESS of the store: mem_en=1, mem_w_en=1, mem_address=0x09, mem_in_data=45. Load rsp_valid appears 2 cycles after accept with rsp_data=45, rsp_err=0.
- PUSH 54, PUSH 4, POP, POP -> first push writes at 0xFF, second at 0xFE. Pops return 4 then 54. sp sequence FF->FE->FD->FE->FF. req_ready low for 2 cycles after each accept.
- POP on empty stack (sp=FF) -> rsp_valid 1 cycle after accept, rsp_err=1, rsp_data=0, mem_en never asserted, sp stays FF. Overflow case: push until sp=8'hBF, next PUSH -> rsp_err=1, no write.
- req_valid held high through ACCESS/RESP with a second STORE 40 @0x01 -> second request accepted only on return to IDLE. Exactly one write pulse per request.
- rst asserted during ACCESS of STORE 14 @0x0D -> mem_en/mem_w_en drop at once, no rsp_valid, sp=FF. A following LOAD @0x0D returns the pre-existing memory value, not 14.
